// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, round count and inverse S-box lookup
package aes_pkg;

  localparam int AES_NR = 10;

  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } dec_state_e;

  localparam logic [0:255][7:0] INV_SBOX = {
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - one combinational AES inverse round, shared by all rounds
module aes_inv_round
  import aes_pkg::*;
(
  input  block_t state_in,
  input  block_t round_key,
  input  logic   last,
  output block_t state_out
);

  block_t w_shifted;
  block_t w_subbed;
  block_t w_added;
  block_t w_mixed;

  // InvShiftRows: row r rotates right by r; byte index is row + 4*column
  always_comb begin
    w_shifted = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        w_shifted[127-8*(r+4*c) -: 8] = state_in[127-8*(r+4*((c+4-r)%4)) -: 8];
      end
    end
  end

  // InvSubBytes on every byte of the shifted state
  always_comb begin
    w_subbed = '0;
    for (int i = 0; i < 16; i++) begin
      w_subbed[127-8*i -: 8] = inv_sbox(w_shifted[127-8*i -: 8]);
    end
  end

  assign w_added = w_subbed ^ round_key;

  inv_mix_columns u_inv_mix_columns (
    .i_state (w_added),
    .o_state (w_mixed)
  );

  // The final round skips InvMixColumns
  assign state_out = last ? w_added : w_mixed;

endmodule

// File: rtl/inv_mix_columns.sv
// rtl/inv_mix_columns.sv - combinational AES InvMixColumns over a 128-bit state
module inv_mix_columns
  import aes_pkg::*;
(
  input  block_t i_state,
  output block_t o_state
);

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply one column by the fixed inverse matrix {0e,0b,0d,09} circulant
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] m11 [4];
    logic [7:0] m13 [4];
    logic [7:0] m14 [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]   = col[31-8*i -: 8];
      x2     = xt(a[i]);
      x4     = xt(x2);
      x8     = xt(x4);
      m9[i]  = x8 ^ a[i];
      m11[i] = x8 ^ x2 ^ a[i];
      m13[i] = x8 ^ x4 ^ a[i];
      m14[i] = x8 ^ x4 ^ x2;
    end
    return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
            m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
            m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
            m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
  endfunction

  // Apply the column transform to each of the four state columns
  always_comb begin
    o_state = '0;
    for (int c = 0; c < 4; c++) begin
      o_state[127-32*c -: 32] = inv_mix_col(i_state[127-32*c -: 32]);
    end
  end

endmodule

// File: rtl/aes_dec_round_ctrl.sv
// rtl/aes_dec_round_ctrl.sv - iterative AES-128 decryption sequencer, one round per clock
module aes_dec_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         busy
);

  localparam logic [3:0] LAST_KEY  = 4'(NR);
  localparam logic [3:0] FIRST_RND = 4'(NR - 1);

  dec_state_e r_state;
  dec_state_e w_next_state;
  logic [3:0] r_rnd;
  logic [3:0] w_rnd_next;
  block_t     r_st;
  block_t     w_st_next;
  block_t     w_round_out;
  logic       w_last;
  logic       w_in_ready;
  logic [3:0] w_rk_idx;
  logic       r_out_valid;
  logic       r_busy;

  aes_inv_round u_inv_round (
    .state_in  (r_st),
    .round_key (rk),
    .last      (w_last),
    .state_out (w_round_out)
  );

  // State, round counter, block register and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rnd       <= 4'd0;
      r_st        <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_rnd       <= w_rnd_next;
      r_st        <= w_st_next;
      r_out_valid <= (w_next_state == DONE);
      r_busy      <= (w_next_state == ROUND) || (w_next_state == FINAL);
    end
  end

  // Next-state, datapath select and key index; in_ready/rk_idx depend on state and rnd only
  always_comb begin
    w_next_state = r_state;
    w_rnd_next   = r_rnd;
    w_st_next    = r_st;
    w_last       = 1'b0;
    w_in_ready   = 1'b0;
    w_rk_idx     = 4'd0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        w_rk_idx   = LAST_KEY;
        if (in_valid) begin
          w_st_next    = in_block ^ rk;
          w_rnd_next   = FIRST_RND;
          w_next_state = ROUND;
        end
      end
      ROUND: begin
        w_rk_idx  = r_rnd;
        w_st_next = w_round_out;
        if (r_rnd == 4'd1) begin
          w_next_state = FINAL;
        end else begin
          w_rnd_next = r_rnd - 4'd1;
        end
      end
      FINAL: begin
        w_rk_idx     = 4'd0;
        w_last       = 1'b1;
        w_st_next    = w_round_out;
        w_next_state = DONE;
      end
      DONE: begin
        if (out_ready) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  assign in_ready  = w_in_ready;
  assign rk_idx    = w_rk_idx;
  assign out_valid = r_out_valid;
  assign out_block = r_st;
  assign busy      = r_busy;

endmodule
